mem_addr_sequencer: RTL and testbench

Parametrised, registered successor to the combinational memory address select. It feeds the core's memory port with addresses from four command modes: increment, jump, map and burst. It accepts one command at a time through a valid/ready handshake and holds its output address until downstream accepts it. Burst mode walks a strided, wrap-around address range without further commands, so each core streams matrix rows and columns on its own.

---
 rtl/mem_addr_sequencer_if.sv | 32 +++
 rtl/mem_addr_sequencer.sv | 139 +++++++++++++
 tb/tb_mem_addr_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_addr_sequencer_if.sv
// Command/address bundle for mem_addr_sequencer: command handshake in, address stream out.
interface mem_addr_sequencer_if #(
    parameter int ADDR_W  = 16,
    parameter int JUMP_W  = 7,
    parameter int NUM_MAP = 4,
    parameter int LEN_W   = 8
);
    localparam int IDX_W = (NUM_MAP > 1) ? $clog2(NUM_MAP) : 1;

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [1:0]                cmd_mode;
    logic [JUMP_W-1:0]         jump_addr;
    logic [NUM_MAP*ADDR_W-1:0] map_addr;
    logic [IDX_W-1:0]          map_idx;
    logic [LEN_W-1:0]          burst_len;
    logic [ADDR_W-1:0]         addr_out;
    logic                      addr_valid;
    logic                      addr_ready;
    logic                      addr_last;
    logic                      busy;

    modport master (
        output cmd_valid, cmd_mode, jump_addr, map_addr, map_idx, burst_len, addr_ready,
        input  cmd_ready, addr_out, addr_valid, addr_last, busy
    );

    modport slave (
        input  cmd_valid, cmd_mode, jump_addr, map_addr, map_idx, burst_len, addr_ready,
        output cmd_ready, addr_out, addr_valid, addr_last, busy
    );
endinterface

// File: rtl/mem_addr_sequencer.sv
// Registered memory address sequencer: INC / JUMP / MAP single addresses and strided wrap-around bursts.
//   state   | meaning
//   S_IDLE  | accepting commands; output holds last address (valid or not)
//   S_BURST | walking burst beats; commands refused until the last beat is accepted
module mem_addr_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int JUMP_W  = 7,
    parameter int NUM_MAP = 4,
    parameter int STRIDE  = 1,
    parameter int DEPTH   = 65536,
    parameter int LEN_W   = 8
) (
    input logic clk,
    input logic rst_n,
    mem_addr_sequencer_if.slave bus
);
    localparam int IDX_W = (NUM_MAP > 1) ? $clog2(NUM_MAP) : 1;
    localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] STRIDE_X = (ADDR_W+1)'(STRIDE);
    localparam logic [1:0] MODE_INC  = 2'd0;
    localparam logic [1:0] MODE_JUMP = 2'd1;
    localparam logic [1:0] MODE_MAP  = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;

    logic [ADDR_W:0]   sum;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] jump_ext;
    logic [ADDR_W-1:0] map_sel;
    logic              cmd_ready;
    logic              cmd_fire;
    logic              out_fire;

    // One extra bit on the adder keeps the carry so the wrap compare is exact at DEPTH = 2**ADDR_W.
    assign sum      = {1'b0, addr_q} + STRIDE_X;
    assign addr_inc = (sum >= DEPTH_X) ? ADDR_W'(sum - DEPTH_X) : sum[ADDR_W-1:0];
    assign jump_ext = ADDR_W'(bus.jump_addr);

    always_comb begin
        map_sel = bus.map_addr[0 +: ADDR_W];
        for (int i = 1; i < NUM_MAP; i++) begin
            if (bus.map_idx == IDX_W'(i)) map_sel = bus.map_addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign cmd_ready = (state_q == S_IDLE) && (!valid_q || bus.addr_ready);
    assign cmd_fire  = bus.cmd_valid && cmd_ready;
    assign out_fire  = valid_q && bus.addr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    case (bus.cmd_mode)
                        MODE_INC: begin
                            addr_d  = addr_inc;
                            valid_d = 1'b1;
                            last_d  = 1'b1;
                        end
                        MODE_JUMP: begin
                            addr_d  = jump_ext;
                            valid_d = 1'b1;
                            last_d  = 1'b1;
                        end
                        MODE_MAP: begin
                            addr_d  = map_sel;
                            valid_d = 1'b1;
                            last_d  = 1'b1;
                        end
                        MODE_BURST: begin
                            if (bus.burst_len == '0) begin
                                valid_d = 1'b0;
                                last_d  = 1'b0;
                            end else begin
                                addr_d  = jump_ext;
                                valid_d = 1'b1;
                                last_d  = (bus.burst_len == LEN_W'(1));
                                cnt_d   = bus.burst_len - 1'b1;
                                state_d = S_BURST;
                            end
                        end
                        default: ;
                    endcase
                end else if (out_fire) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            S_BURST: begin
                if (out_fire) begin
                    if (cnt_q != '0) begin
                        addr_d = addr_inc;
                        cnt_d  = cnt_q - 1'b1;
                        last_d = (cnt_q == LEN_W'(1));
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.addr_out   = addr_q;
    assign bus.addr_valid = valid_q;
    assign bus.addr_last  = last_q;
    assign bus.busy       = (state_q == S_BURST);
endmodule

// File: tb/tb_mem_addr_sequencer.sv
// Scoreboard bench for mem_addr_sequencer: default instance A and a small wrap-around instance B.
module tb_mem_addr_sequencer;
    typedef struct packed {
        logic [15:0] addr;
        logic        last;
        logic        busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cva = 1'b0, cvb = 1'b0;
    logic        rdy_a = 1'b1, rdy_b = 1'b1;
    logic [1:0]  cmd_mode = '0;
    logic [6:0]  jump_addr = '0;
    logic [1:0]  map_idx = '0;
    logic [7:0]  burst_len = '0;
    logic [63:0] map_a = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
    logic [47:0] map_b = {16'h0009, 16'h0005, 16'h0007};

    int checks = 0;
    int failures = 0;
    exp_t sba[$];
    exp_t sbb[$];

    mem_addr_sequencer_if #(.ADDR_W(16), .JUMP_W(7), .NUM_MAP(4), .LEN_W(8)) ia ();
    mem_addr_sequencer_if #(.ADDR_W(16), .JUMP_W(7), .NUM_MAP(3), .LEN_W(8)) ib ();

    assign ia.cmd_valid = cva;
    assign ia.cmd_mode = cmd_mode;
    assign ia.jump_addr = jump_addr;
    assign ia.map_addr = map_a;
    assign ia.map_idx = map_idx;
    assign ia.burst_len = burst_len;
    assign ia.addr_ready = rdy_a;
    assign ib.cmd_valid = cvb;
    assign ib.cmd_mode = cmd_mode;
    assign ib.jump_addr = jump_addr;
    assign ib.map_addr = map_b;
    assign ib.map_idx = map_idx;
    assign ib.burst_len = burst_len;
    assign ib.addr_ready = rdy_b;

    mem_addr_sequencer #(.ADDR_W(16), .JUMP_W(7), .NUM_MAP(4), .STRIDE(1), .DEPTH(65536), .LEN_W(8))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    mem_addr_sequencer #(.ADDR_W(16), .JUMP_W(7), .NUM_MAP(3), .STRIDE(3), .DEPTH(16), .LEN_W(8))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    always #5 clk = ~clk;

    // Monitor A: pops on every accepted beat and checks that stalled beats are held unchanged.
    logic        stall_a = 1'b0, held_last_a = 1'b0;
    logic [15:0] held_a = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) stall_a = 1'b0;
        else begin
            if (stall_a && ia.addr_valid) begin
                checks++;
                if (ia.addr_out !== held_a || ia.addr_last !== held_last_a) begin
                    failures++;
                    $display("FAIL hold_a got addr=%h last=%b exp addr=%h last=%b", ia.addr_out, ia.addr_last, held_a, held_last_a);
                end
            end
            if (ia.addr_valid && ia.addr_ready) begin
                checks++;
                if (sba.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_a got addr=%h with empty scoreboard", ia.addr_out);
                end else begin
                    e = sba.pop_front();
                    if (ia.addr_out !== e.addr || ia.addr_last !== e.last || ia.busy !== e.busy || ia.cmd_ready !== !e.busy) begin
                        failures++;
                        $display("FAIL beat_a got addr=%h last=%b busy=%b cmd_ready=%b exp addr=%h last=%b busy=%b cmd_ready=%b",
                                 ia.addr_out, ia.addr_last, ia.busy, ia.cmd_ready, e.addr, e.last, e.busy, !e.busy);
                    end
                end
            end
            stall_a = ia.addr_valid && !ia.addr_ready;
            held_a = ia.addr_out;
            held_last_a = ia.addr_last;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ib.addr_valid && ib.addr_ready) begin
            checks++;
            if (sbb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_b got addr=%h with empty scoreboard", ib.addr_out);
            end else begin
                e = sbb.pop_front();
                if (ib.addr_out !== e.addr || ib.addr_last !== e.last || ib.busy !== e.busy || ib.cmd_ready !== !e.busy) begin
                    failures++;
                    $display("FAIL beat_b got addr=%h last=%b busy=%b cmd_ready=%b exp addr=%h last=%b busy=%b cmd_ready=%b",
                             ib.addr_out, ib.addr_last, ib.busy, ib.cmd_ready, e.addr, e.last, e.busy, !e.busy);
                end
            end
        end
    end

    task automatic push(input bit sel, input logic [15:0] a, input logic l, input logic b);
        exp_t e;
        e.addr = a; e.last = l; e.busy = b;
        if (sel) sbb.push_back(e); else sba.push_back(e);
    endtask

    // Drives one command, waits (bounded) for acceptance, then checks the one-cycle latency.
    task automatic issue(input bit sel, input logic [1:0] mode, input logic [6:0] ja,
                         input logic [1:0] idx, input logic [7:0] len);
        int n = 0;
        logic exp_v;
        @(negedge clk);
        cmd_mode = mode; jump_addr = ja; map_idx = idx; burst_len = len;
        if (sel) cvb = 1'b1; else cva = 1'b1;
        while (!(sel ? ib.cmd_ready : ia.cmd_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            failures++;
            $display("FAIL cmd_timeout sel=%0d mode=%0d never accepted", sel, mode);
        end
        @(posedge clk);
        #1;
        cva = 1'b0; cvb = 1'b0;
        exp_v = !(mode == 2'd3 && len == 8'd0);
        checks++;
        if ((sel ? ib.addr_valid : ia.addr_valid) !== exp_v) begin
            failures++;
            $display("FAIL latency sel=%0d mode=%0d got addr_valid=%b exp %b", sel, mode,
                     sel ? ib.addr_valid : ia.addr_valid, exp_v);
        end
    endtask

    task automatic drain(input bit sel);
        int n = 0;
        while ((sel ? sbb.size() : sba.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++;
        if ((sel ? sbb.size() : sba.size()) != 0) begin
            failures++;
            $display("FAIL drain sel=%0d got %0d pending beats exp 0", sel, sel ? sbb.size() : sba.size());
        end
    endtask

    task automatic check_idle_reset(input string name);
        checks++;
        if (ia.addr_out !== 16'h0 || ia.addr_valid !== 1'b0 || ia.addr_last !== 1'b0 ||
            ia.busy !== 1'b0 || ia.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s got addr=%h valid=%b last=%b busy=%b cmd_ready=%b exp 0000 0 0 0 1", name,
                     ia.addr_out, ia.addr_valid, ia.addr_last, ia.busy, ia.cmd_ready);
        end
    endtask

    task automatic pulse_reset(input string name);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sba.delete();
        sbb.delete();
        #1;
        check_idle_reset(name);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state of both instances
        repeat (2) @(posedge clk);
        #1;
        check_idle_reset("reset_a");
        checks++;
        if (ib.addr_out !== 16'h0 || ib.addr_valid !== 1'b0 || ib.busy !== 1'b0 || ib.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_b got addr=%h valid=%b busy=%b cmd_ready=%b exp 0000 0 0 1",
                     ib.addr_out, ib.addr_valid, ib.busy, ib.cmd_ready);
        end
        rst_n = 1'b1;

        // INC x3 from 0
        for (int i = 1; i <= 3; i++) begin
            push(0, 16'(i), 1'b1, 1'b0);
            issue(0, 2'd0, 7'h0, 2'd0, 8'd0);
        end
        drain(0);

        // Reset asynchronously in the middle of a burst
        push(0, 16'h0020, 1'b0, 1'b1);
        push(0, 16'h0021, 1'b0, 1'b1);
        issue(0, 2'd3, 7'h20, 2'd0, 8'd8);
        pulse_reset("reset_mid_burst");

        // JUMP, MAP entry 2, MAP out-of-range index on the 3-entry instance
        push(0, 16'h0055, 1'b1, 1'b0);
        issue(0, 2'd1, 7'h55, 2'd0, 8'd0);
        push(0, 16'hBEEF, 1'b1, 1'b0);
        issue(0, 2'd2, 7'h0, 2'd2, 8'd0);
        push(1, 16'h0009, 1'b1, 1'b0);
        issue(1, 2'd2, 7'h0, 2'd2, 8'd0);
        push(1, 16'h0007, 1'b1, 1'b0);
        issue(1, 2'd2, 7'h0, 2'd3, 8'd0);
        drain(0);
        drain(1);

        // Burst base 10 len 4, back-to-back beats
        for (int i = 0; i < 4; i++) push(0, 16'(10 + i), (i == 3), 1'b1);
        issue(0, 2'd3, 7'd10, 2'd0, 8'd4);
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (sba.size() != 0) begin
            failures++;
            $display("FAIL burst_rate got %0d beats left after 4 cycles exp 0", sba.size());
        end
        @(posedge clk);
        #1;
        checks++;
        if (ia.busy !== 1'b0 || ia.cmd_ready !== 1'b1 || ia.addr_valid !== 1'b0) begin
            failures++;
            $display("FAIL burst_end got busy=%b cmd_ready=%b valid=%b exp 0 1 0", ia.busy, ia.cmd_ready, ia.addr_valid);
        end

        // Same burst with addr_ready toggling every cycle
        for (int i = 0; i < 4; i++) push(0, 16'(10 + i), (i == 3), 1'b1);
        issue(0, 2'd3, 7'd10, 2'd0, 8'd4);
        for (int n = 0; n < 100 && sba.size() != 0; n++) begin
            rdy_a = ~rdy_a;
            @(posedge clk);
            #1;
        end
        rdy_a = 1'b1;
        drain(0);

        // Wrap-around on DEPTH=16, STRIDE=3
        push(1, 16'd12, 1'b0, 1'b1);
        push(1, 16'd15, 1'b0, 1'b1);
        push(1, 16'd2, 1'b1, 1'b1);
        issue(1, 2'd3, 7'd12, 2'd0, 8'd3);
        drain(1);
        push(1, 16'd15, 1'b1, 1'b0);
        issue(1, 2'd1, 7'd15, 2'd0, 8'd0);
        push(1, 16'd2, 1'b1, 1'b0);
        issue(1, 2'd0, 7'd0, 2'd0, 8'd0);
        push(1, 16'd5, 1'b1, 1'b0);
        issue(1, 2'd0, 7'd0, 2'd0, 8'd0);
        drain(1);

        // Zero-length burst produces nothing and leaves the sequencer ready
        issue(0, 2'd3, 7'h33, 2'd0, 8'd0);
        checks++;
        if (ia.cmd_ready !== 1'b1 || ia.busy !== 1'b0) begin
            failures++;
            $display("FAIL burst_len0 got cmd_ready=%b busy=%b exp 1 0", ia.cmd_ready, ia.busy);
        end

        // Burst len 5 with reset after beat 2, then a normal JUMP
        push(0, 16'h0040, 1'b0, 1'b1);
        push(0, 16'h0041, 1'b0, 1'b1);
        issue(0, 2'd3, 7'h40, 2'd0, 8'd5);
        @(posedge clk);
        pulse_reset("reset_after_beat2");
        push(0, 16'h0012, 1'b1, 1'b0);
        issue(0, 2'd1, 7'h12, 2'd0, 8'd0);
        drain(0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
